// File: rtl/freeblk_arb_if.sv
// rtl/freeblk_arb_if.sv - pool and requester handshake bundle for freeblk_arb
interface freeblk_arb_if #(
    parameter int ADDBLK = 11,
    parameter int NREQ   = 4,
    parameter int ADDCNT = 10
);
    logic                   pool_rdy;
    logic                   pool_get;
    logic [ADDBLK-1:0]      pool_id;
    logic                   pool_free;
    logic [ADDBLK-1:0]      pool_freeid;
    logic [NREQ-1:0]        cli_rdy;
    logic [NREQ-1:0]        cli_get;
    logic [NREQ*ADDBLK-1:0] cli_id;
    logic [NREQ-1:0]        cli_free;
    logic [NREQ*ADDBLK-1:0] cli_freeid;
    logic [NREQ-1:0]        cli_freerdy;
    logic [NREQ*ADDCNT-1:0] cli_cnt;
    logic                   err_gap;
    logic                   err_und;

    modport master (
        input  pool_rdy, pool_id, cli_get, cli_free, cli_freeid,
        output pool_get, pool_free, pool_freeid, cli_rdy, cli_id,
               cli_freerdy, cli_cnt, err_gap, err_und
    );

    modport slave (
        output pool_rdy, pool_id, cli_get, cli_free, cli_freeid,
        input  pool_get, pool_free, pool_freeid, cli_rdy, cli_id,
               cli_freerdy, cli_cnt, err_gap, err_und
    );
endinterface

// File: rtl/freeblk_arb.sv
// rtl/freeblk_arb.sv - shares one free-block pool among NREQ requesters
module freeblk_arb #(
    parameter int ADDBLK = 11,
    parameter int NREQ   = 4,
    parameter int ADDREQ = 2,
    parameter int QUOTA  = 512,
    parameter int ADDCNT = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active,
    freeblk_arb_if.master bus
);
    localparam logic [ADDCNT-1:0] QMAX = ADDCNT'(QUOTA);

    logic [NREQ-1:0]   slot_vld_q, slot_vld_d;
    logic [NREQ-1:0]   ret_vld_q, ret_vld_d;
    logic [ADDBLK-1:0] slot_id_q [NREQ];
    logic [ADDBLK-1:0] slot_id_d [NREQ];
    logic [ADDBLK-1:0] ret_id_q  [NREQ];
    logic [ADDBLK-1:0] ret_id_d  [NREQ];
    logic [ADDCNT-1:0] cnt_q     [NREQ];
    logic [ADDCNT-1:0] cnt_d     [NREQ];
    logic [ADDREQ-1:0] fill_ptr_q, fill_ptr_d, ret_ptr_q, ret_ptr_d;
    logic              pool_free_q, pool_free_d;
    logic [ADDBLK-1:0] pool_freeid_q, pool_freeid_d;
    logic              err_gap_q, err_gap_d, err_und_q, err_und_d;

    logic              run;
    logic [NREQ-1:0]   elig, gnt, acc, drop, keep;
    logic              gnt_vld, gnt_fire, ret_sel_vld;
    logic [ADDREQ-1:0] gnt_idx, ret_sel_idx;

    // First set bit of req at or after ptr, wrapping; MSB of result flags a hit.
    function automatic logic [ADDREQ:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [ADDREQ-1:0] ptr);
        logic [ADDREQ-1:0] idx;
        rr_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ADDREQ'((int'(ptr) + k) % NREQ);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign run = active & rst;
    assign {gnt_vld, gnt_idx}         = rr_pick(elig, fill_ptr_q);
    assign {ret_sel_vld, ret_sel_idx} = rr_pick(ret_vld_q, ret_ptr_q);
    assign gnt_fire = gnt_vld & bus.pool_rdy;

    always_comb begin
        elig = '0;
        gnt  = '0;
        acc  = '0;
        drop = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = run && !slot_vld_q[i] && (cnt_q[i] < QMAX);
            gnt[i]  = gnt_fire && (gnt_idx == ADDREQ'(i));
            acc[i]  = bus.cli_free[i] && !ret_vld_q[i];
            // A grant in the same cycle covers the release, so it is not an underflow.
            drop[i] = acc[i] && (cnt_q[i] == '0) && !gnt[i];
        end
    end
    assign keep = acc & ~drop;

    always_comb begin
        slot_vld_d    = slot_vld_q;
        ret_vld_d     = ret_vld_q;
        slot_id_d     = slot_id_q;
        ret_id_d      = ret_id_q;
        cnt_d         = cnt_q;
        fill_ptr_d    = fill_ptr_q;
        ret_ptr_d     = ret_ptr_q;
        pool_free_d   = 1'b0;
        pool_freeid_d = '0;
        err_gap_d     = |(bus.cli_get & ~slot_vld_q);
        err_und_d     = |drop;

        if (ret_sel_vld) begin
            pool_free_d            = 1'b1;
            pool_freeid_d          = ret_id_q[ret_sel_idx];
            ret_vld_d[ret_sel_idx] = 1'b0;
            ret_ptr_d              = ADDREQ'((int'(ret_sel_idx) + 1) % NREQ);
        end
        if (gnt_fire) begin
            slot_vld_d[gnt_idx] = 1'b1;
            slot_id_d[gnt_idx]  = bus.pool_id;
            fill_ptr_d          = ADDREQ'((int'(gnt_idx) + 1) % NREQ);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.cli_get[i] && slot_vld_q[i]) slot_vld_d[i] = 1'b0;
            if (keep[i]) begin
                ret_vld_d[i] = 1'b1;
                ret_id_d[i]  = bus.cli_freeid[i*ADDBLK +: ADDBLK];
            end
            if (gnt[i] && !keep[i] && cnt_q[i] != QMAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (keep[i] && !gnt[i] && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !active) begin
            slot_vld_q    <= '0;
            ret_vld_q     <= '0;
            fill_ptr_q    <= '0;
            ret_ptr_q     <= '0;
            pool_free_q   <= 1'b0;
            pool_freeid_q <= '0;
            err_gap_q     <= 1'b0;
            err_und_q     <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_id_q[i] <= '0;
                ret_id_q[i]  <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            slot_vld_q    <= slot_vld_d;
            ret_vld_q     <= ret_vld_d;
            fill_ptr_q    <= fill_ptr_d;
            ret_ptr_q     <= ret_ptr_d;
            pool_free_q   <= pool_free_d;
            pool_freeid_q <= pool_freeid_d;
            err_gap_q     <= err_gap_d;
            err_und_q     <= err_und_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_id_q[i] <= slot_id_d[i];
                ret_id_q[i]  <= ret_id_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
        end
    end

    assign bus.pool_get    = gnt_fire;
    assign bus.pool_free   = pool_free_q;
    assign bus.pool_freeid = pool_freeid_q;
    assign bus.cli_rdy     = slot_vld_q;
    assign bus.cli_freerdy = ~ret_vld_q;
    assign bus.err_gap     = err_gap_q;
    assign bus.err_und     = err_und_q;

    always_comb begin
        bus.cli_id  = '0;
        bus.cli_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.cli_id[i*ADDBLK +: ADDBLK]  = slot_id_q[i];
            bus.cli_cnt[i*ADDCNT +: ADDCNT] = cnt_q[i];
        end
    end
endmodule
